// File: rtl/airlock_sequencer.sv
// Airlock interlock controller: door sequencing plus pressurize, evacuate and
// dwell countdowns in one tick-enabled block. All outputs are registered.
module airlock_sequencer #(
  parameter int CNT_W       = 4,
  parameter int PRESS_TICKS = 7,
  parameter int EVAC_TICKS  = 8,
  parameter int DWELL_TICKS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             evac_cmd,
  input  logic             press_cmd,
  input  logic             inner_req,
  input  logic             outer_req,
  input  logic             occupied,
  output logic             inner_open,
  output logic             outer_open,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic             reject
);

  localparam logic [2:0] PH_PRESS_IDLE = 3'd0;
  localparam logic [2:0] PH_EVAC       = 3'd1;
  localparam logic [2:0] PH_VAC_IDLE   = 3'd2;
  localparam logic [2:0] PH_DWELL      = 3'd3;
  localparam logic [2:0] PH_PRESS      = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] PRESS_LD = CNT_W'(PRESS_TICKS);
  localparam logic [CNT_W-1:0] EVAC_LD  = CNT_W'(EVAC_TICKS);
  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_TICKS);

  logic [2:0]       phase_r;
  logic [2:0]       phase_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             inner_open_r;
  logic             outer_open_r;
  logic             done_r;
  logic             reject_r;
  logic             inner_nxt_s;
  logic             outer_nxt_s;
  logic             done_nxt_s;
  logic             reject_nxt_s;
  logic             expire_s;

  function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
    cnt_dec = (c == CNT_ZERO) ? CNT_ZERO : (c - CNT_ONE);
  endfunction

  // A count of 1 (or a corrupted 0) means this tick finishes the timed state.
  assign expire_s = (count_r <= CNT_ONE);

  // State register: phase and remaining count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_r <= PH_PRESS_IDLE;
      count_r <= CNT_ZERO;
    end else begin
      phase_r <= phase_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Next-state logic: transitions, counter loads/decrements, done/reject events.
  always_comb begin
    phase_nxt_s  = phase_r;
    count_nxt_s  = count_r;
    done_nxt_s   = 1'b0;
    reject_nxt_s = 1'b0;
    case (phase_r)
      PH_PRESS_IDLE: begin
        count_nxt_s = CNT_ZERO;
        if (evac_cmd) begin
          if (!inner_req && !inner_open_r) begin
            phase_nxt_s = PH_EVAC;
            count_nxt_s = EVAC_LD;
          end else begin
            reject_nxt_s = 1'b1;
          end
        end else begin
          phase_nxt_s = PH_PRESS_IDLE;
        end
      end
      PH_EVAC: begin
        if (press_cmd) begin
          phase_nxt_s = PH_PRESS;
          count_nxt_s = PRESS_LD;
        end else if (tick) begin
          if (expire_s) begin
            phase_nxt_s = PH_VAC_IDLE;
            count_nxt_s = CNT_ZERO;
            done_nxt_s  = 1'b1;
          end else begin
            count_nxt_s = cnt_dec(count_r);
          end
        end else begin
          count_nxt_s = count_r;
        end
      end
      PH_VAC_IDLE: begin
        count_nxt_s = CNT_ZERO;
        if (press_cmd) begin
          if (!outer_req && !outer_open_r) begin
            if (occupied) begin
              phase_nxt_s = PH_DWELL;
              count_nxt_s = DWELL_LD;
            end else begin
              phase_nxt_s = PH_PRESS;
              count_nxt_s = PRESS_LD;
            end
          end else begin
            reject_nxt_s = 1'b1;
          end
        end else begin
          phase_nxt_s = PH_VAC_IDLE;
        end
      end
      PH_DWELL: begin
        // Someone reaching for the outer door cancels the dwell, even on a tick.
        if (outer_req) begin
          phase_nxt_s = PH_VAC_IDLE;
          count_nxt_s = CNT_ZERO;
        end else if (tick) begin
          if (expire_s) begin
            phase_nxt_s = PH_PRESS;
            count_nxt_s = PRESS_LD;
            done_nxt_s  = 1'b1;
          end else begin
            count_nxt_s = cnt_dec(count_r);
          end
        end else begin
          count_nxt_s = count_r;
        end
      end
      PH_PRESS: begin
        if (evac_cmd) begin
          phase_nxt_s = PH_EVAC;
          count_nxt_s = EVAC_LD;
        end else if (tick) begin
          if (expire_s) begin
            phase_nxt_s = PH_PRESS_IDLE;
            count_nxt_s = CNT_ZERO;
            done_nxt_s  = 1'b1;
          end else begin
            count_nxt_s = cnt_dec(count_r);
          end
        end else begin
          count_nxt_s = count_r;
        end
      end
      default: begin
        phase_nxt_s = PH_PRESS_IDLE;
        count_nxt_s = CNT_ZERO;
      end
    endcase
  end

  // Output logic: a door may only follow its request while staying in its idle phase.
  always_comb begin
    inner_nxt_s = 1'b0;
    outer_nxt_s = 1'b0;
    if ((phase_r == PH_PRESS_IDLE) && (phase_nxt_s == PH_PRESS_IDLE)) begin
      inner_nxt_s = inner_req;
    end else begin
      inner_nxt_s = 1'b0;
    end
    if ((phase_r == PH_VAC_IDLE) && (phase_nxt_s == PH_VAC_IDLE)) begin
      outer_nxt_s = outer_req;
    end else begin
      outer_nxt_s = 1'b0;
    end
  end

  // Output registers: door drives and event strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inner_open_r <= 1'b0;
      outer_open_r <= 1'b0;
      done_r       <= 1'b0;
      reject_r     <= 1'b0;
    end else begin
      inner_open_r <= inner_nxt_s;
      outer_open_r <= outer_nxt_s;
      done_r       <= done_nxt_s;
      reject_r     <= reject_nxt_s;
    end
  end

  assign inner_open = inner_open_r;
  assign outer_open = outer_open_r;
  assign phase      = phase_r;
  assign count      = count_r;
  assign done       = done_r;
  assign reject     = reject_r;

  airlock_sequencer_chk u_chk (
    .clk        (clk),
    .reset      (reset),
    .inner_open (inner_open_r),
    .outer_open (outer_open_r),
    .phase      (phase_r)
  );

endmodule

// Interlock properties for the airlock: doors exclusive, phase code legal.
module airlock_sequencer_chk (
  input logic       clk,
  input logic       reset,
  input logic       inner_open,
  input logic       outer_open,
  input logic [2:0] phase
);

  a_doors_exclusive: assert property (@(posedge clk) disable iff (!reset)
    !(inner_open && outer_open));

  a_phase_legal: assert property (@(posedge clk) disable iff (!reset)
    (phase <= 3'd4));

endmodule

// File: tb/tb_airlock_sequencer.sv
// Bench for airlock_sequencer: directed scenarios plus random stimulus, all
// checked every cycle against a behavioural model of the airlock rules.
module tb_airlock_sequencer;

  localparam int CW = 4;
  localparam int PT = 7;
  localparam int ET = 8;
  localparam int DT = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          evac_cmd = 1'b0;
  logic          press_cmd = 1'b0;
  logic          inner_req = 1'b0;
  logic          outer_req = 1'b0;
  logic          occupied = 1'b0;
  logic          inner_open;
  logic          outer_open;
  logic [2:0]    phase;
  logic [CW-1:0] count;
  logic          done;
  logic          reject;

  int n_checks = 0;
  int n_errors = 0;

  airlock_sequencer #(.CNT_W(CW), .PRESS_TICKS(PT), .EVAC_TICKS(ET), .DWELL_TICKS(DT)) dut (
    .clk(clk), .reset(rst_n), .tick(tick), .evac_cmd(evac_cmd), .press_cmd(press_cmd),
    .inner_req(inner_req), .outer_req(outer_req), .occupied(occupied),
    .inner_open(inner_open), .outer_open(outer_open), .phase(phase),
    .count(count), .done(done), .reject(reject)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ph;
    int cnt;
    bit inr;
    bit outr;
    bit dn;
    bit rj;
  } mstate_t;

  mstate_t m = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0};

  // Airlock rules applied to the current model state and the inputs of this cycle.
  function automatic mstate_t model_next(input mstate_t s);
    mstate_t n;
    n = '{s.ph, s.cnt, 1'b0, 1'b0, 1'b0, 1'b0};
    case (s.ph)
      0: begin
        n.cnt = 0;
        n.inr = inner_req;
        if (evac_cmd) begin
          if (!inner_req && !s.inr) begin
            n.ph = 1; n.cnt = ET; n.inr = 1'b0;
          end else begin
            n.rj = 1'b1;
          end
        end
      end
      1: begin
        if (press_cmd) begin
          n.ph = 4; n.cnt = PT;
        end else if (tick) begin
          n.cnt = s.cnt - 1;
          if (n.cnt <= 0) begin n.cnt = 0; n.dn = 1'b1; n.ph = 2; end
        end
      end
      2: begin
        n.cnt = 0;
        n.outr = outer_req;
        if (press_cmd) begin
          if (!outer_req && !s.outr) begin
            n.outr = 1'b0;
            if (occupied) begin n.ph = 3; n.cnt = DT; end
            else begin n.ph = 4; n.cnt = PT; end
          end else begin
            n.rj = 1'b1;
          end
        end
      end
      3: begin
        if (outer_req) begin
          n.ph = 2; n.cnt = 0;
        end else if (tick) begin
          n.cnt = s.cnt - 1;
          if (n.cnt <= 0) begin n.dn = 1'b1; n.ph = 4; n.cnt = PT; end
        end
      end
      4: begin
        if (evac_cmd) begin
          n.ph = 1; n.cnt = ET;
        end else if (tick) begin
          n.cnt = s.cnt - 1;
          if (n.cnt <= 0) begin n.cnt = 0; n.dn = 1'b1; n.ph = 0; end
        end
      end
      default: begin
        n.ph = 0; n.cnt = 0;
      end
    endcase
    return n;
  endfunction

  // Reference model advances on the same edges as the design.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    else        m <= model_next(m);
  end

  task automatic check(input string nm, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("phase", int'(phase), m.ph);
    check("count", int'(count), m.cnt);
    check("inner_open", int'(inner_open), int'(m.inr));
    check("outer_open", int'(outer_open), int'(m.outr));
    check("done", int'(done), int'(m.dn));
    check("reject", int'(reject), int'(m.rj));
    check("doors_exclusive", int'(inner_open & outer_open), 0);
  end

  task automatic step(input bit t);
    tick = t;
    @(negedge clk);
  endtask

  int dones;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step(1'b0);
    check("lit_reset_phase", int'(phase), 0);
    check("lit_reset_count", int'(count), 0);

    // Evacuate with a tick every 4th cycle.
    evac_cmd = 1'b1; step(1'b0); evac_cmd = 1'b0;
    check("lit_evac_phase", int'(phase), 1);
    check("lit_evac_load", int'(count), 8);
    dones = 0;
    for (int i = 0; i < 32; i++) begin
      step(i % 4 == 0);
      if (done) dones = dones + 1;
    end
    check("lit_evac_done_once", dones, 1);
    check("lit_vac_idle", int'(phase), 2);
    outer_req = 1'b1; step(1'b0);
    check("lit_outer_follows", int'(outer_open), 1);
    outer_req = 1'b0; step(1'b0);

    // Occupied pressurize: dwell then press.
    occupied = 1'b1; press_cmd = 1'b1; step(1'b0); press_cmd = 1'b0;
    check("lit_dwell_load", int'(count), 5);
    repeat (5) step(1'b1);
    check("lit_dwell_done", int'(done), 1);
    check("lit_press_phase", int'(phase), 4);
    check("lit_press_load", int'(count), 7);
    repeat (7) step(1'b1);
    check("lit_press_done_phase", int'(phase), 0);
    inner_req = 1'b1; step(1'b0);
    check("lit_inner_follows", int'(inner_open), 1);

    // Evacuate refused while the inner door is requested.
    evac_cmd = 1'b1; step(1'b0); evac_cmd = 1'b0;
    check("lit_reject_pulse", int'(reject), 1);
    check("lit_reject_phase", int'(phase), 0);
    check("lit_reject_inner", int'(inner_open), 1);
    step(1'b0);
    check("lit_reject_one_cycle", int'(reject), 0);
    inner_req = 1'b0; step(1'b0);

    // Dwell aborted by outer_req on a tick cycle.
    evac_cmd = 1'b1; step(1'b0); evac_cmd = 1'b0;
    repeat (8) step(1'b1);
    press_cmd = 1'b1; step(1'b0); press_cmd = 1'b0;
    repeat (2) step(1'b1);
    check("lit_dwell_count3", int'(count), 3);
    outer_req = 1'b1; step(1'b1);
    check("lit_abort_phase", int'(phase), 2);
    check("lit_abort_count", int'(count), 0);
    check("lit_abort_no_done", int'(done), 0);
    step(1'b0);
    check("lit_abort_outer", int'(outer_open), 1);
    outer_req = 1'b0; step(1'b0);

    // Unoccupied pressurize, then evacuation aborted by press_cmd.
    occupied = 1'b0; press_cmd = 1'b1; step(1'b0); press_cmd = 1'b0;
    repeat (7) step(1'b1);
    evac_cmd = 1'b1; step(1'b0); evac_cmd = 1'b0;
    repeat (4) step(1'b1);
    check("lit_evac_count4", int'(count), 4);
    press_cmd = 1'b1; step(1'b1); press_cmd = 1'b0;
    check("lit_evac_abort_phase", int'(phase), 4);
    check("lit_evac_abort_count", int'(count), 7);

    // Asynchronous reset in the middle of PRESS.
    repeat (5) step(1'b1);
    check("lit_press_count2", int'(count), 2);
    #2 rst_n = 1'b0;
    #1;
    check("lit_async_phase", int'(phase), 0);
    check("lit_async_count", int'(count), 0);
    check("lit_async_doors", int'(inner_open | outer_open), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick = 1'b0;
    step(1'b0);

    // Random stimulus, compared every cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      evac_cmd  = ($urandom_range(0, 7) == 0);
      press_cmd = ($urandom_range(0, 7) == 0);
      inner_req = ($urandom_range(0, 2) == 0);
      outer_req = ($urandom_range(0, 2) == 0);
      occupied  = ($urandom_range(0, 1) == 0);
      tick      = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
